// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots a SIZE x SIZE systolic-array result matrix on a
// start pulse and streams it out row-major over a valid/ready interface.
//   clk, rst       rising-edge clock, synchronous active-low reset
//   start          capture res_in and begin a drain
//   res_in         flattened matrix, element (r,c) at [(r*SIZE+c)*2*WL +: 2*WL]
//   m_data/m_row/m_col/m_last/m_valid, m_ready   output stream
//   busy           drain in progress
//   drop_err       sticky: a start arrived while draining and was discarded
//   frame_cnt      completed frames, modulo 256
module sa_result_drain #(
  parameter int SIZE = 3,
  parameter int WL   = 8,
  localparam int IW  = $clog2(SIZE),
  localparam int DW  = 2*WL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SIZE*SIZE*DW-1:0] res_in,
  output logic [DW-1:0]           m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IW-1:0]           m_row,
  output logic [IW-1:0]           m_col,
  output logic                    m_last,
  output logic                    busy,
  output logic                    drop_err,
  output logic [7:0]              frame_cnt
);

  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE-1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
  state_t state_q, state_d;

  // Packed view matches the flattened layout of res_in exactly, so [r][c]
  // selects element (r,c) with no index arithmetic.
  logic [SIZE-1:0][SIZE-1:0][DW-1:0] snap_q, snap_d;
  logic [IW-1:0] row_q, row_d, col_q, col_d;
  logic          drop_q, drop_d;
  logic [7:0]    frame_q, frame_d;

  logic at_last, xfer, fin, accept;

  assign at_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign xfer    = (state_q == STREAM) && m_ready;
  assign fin     = xfer && at_last;
  // A start is taken from IDLE, or on the very edge the final beat leaves.
  assign accept  = start && ((state_q == IDLE) || fin);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (fin && !start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    m_valid = (state_q == STREAM);
    busy    = (state_q == STREAM);
    m_last  = (state_q == STREAM) && at_last;
    m_data  = (state_q == STREAM) ? snap_q[row_q][col_q] : '0;
  end

  assign m_row     = row_q;
  assign m_col     = col_q;
  assign drop_err  = drop_q;
  assign frame_cnt = frame_q;

  // Datapath next state
  always_comb begin
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    drop_d  = drop_q;
    frame_d = frame_q;
    if (accept) begin
      snap_d = res_in;
      row_d  = '0;
      col_d  = '0;
    end else if (xfer) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + IW'(1);
      end else begin
        col_d = col_q + IW'(1);
      end
    end
    if (fin) frame_d = frame_q + 8'd1;
    if (start && !accept) drop_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      drop_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drop_q  <= drop_d;
      frame_q <= frame_d;
    end
  end

endmodule
